// File: rtl/pool_flatten_buffer.sv
// Single-frame flatten buffer between the max-pool stage and the dense layer.
// It fills DEPTH pooled samples, then streams them out in raster order with a valid/ready handshake.
module pool_flatten_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH_IMG  = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int OUT_DIM = WIDTH_IMG / 2;
  localparam int DEPTH   = OUT_DIM * OUT_DIM;
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  fill_write;
  logic                  handshake;

  assign fill_write = (state == FILL) && in_valid;
  assign out_valid  = (state == DRAIN);
  assign handshake  = out_valid && out_ready;
  assign out_last   = (state == DRAIN) && (rd_idx == LAST_IDX);
  assign out_data   = (state == DRAIN) ? mem[rd_idx] : '0;

  // Storage has no reset; only FILL writes reach it, so samples arriving in DRAIN never corrupt a frame.
  always_ff @(posedge clk) begin
    if (!rst && fill_write) begin
      mem[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wr_idx     <= '0;
      rd_idx     <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (in_valid) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx <= '0;
              state  <= DRAIN;
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (in_valid) begin
            overflow <= 1'b1;
          end
          if (handshake) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx     <= '0;
              state      <= FILL;
              frame_done <= 1'b1;
            end else begin
              rd_idx <= rd_idx + IDX_W'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_flatten_buffer.sv
// Directed bench for pool_flatten_buffer: fill/drain latency, backpressure, sparse input cadence,
// overflow, mid-frame reset and back-to-back frames.
module tb_pool_flatten_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 169;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          frame_done;
  logic          overflow;

  int vectors    = 0;
  int miscompares = 0;

  pool_flatten_buffer #(.DATA_WIDTH(DW), .WIDTH_IMG(26)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Writes n samples base..base+n-1, each followed by gap-1 idle cycles; DRAIN must only appear after the 169th.
  task automatic writeSamples(input int base, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, DW'(base + i), 1'b1);
      @(negedge clk);
      if (i == DEPTH - 1) begin
        checkOutput("first_valid", 32'(out_valid), 32'd1);
        checkOutput("first_data", out_data, DW'(base));
      end else begin
        checkOutput("fill_valid_low", 32'(out_valid), 32'd0);
        for (int g = 1; g < gap; g++) begin
          applyStimulus(1'b0, '0, 1'b1);
          @(negedge clk);
          checkOutput("idle_valid_low", 32'(out_valid), 32'd0);
        end
      end
    end
    applyStimulus(1'b0, '0, 1'b1);
  endtask

  // Drains one frame; returns in the frame_done cycle so the caller may start the next frame there.
  task automatic drainFrame(input int base, input bit toggle, input bit inject);
    int k = 0;
    int c = 0;
    int expCycles;
    logic r;
    expCycles = toggle ? 2 * DEPTH - 1 : (inject ? DEPTH + 1 : DEPTH);
    while (k < DEPTH && c < 1000) begin
      checkOutput("drain_valid", 32'(out_valid), 32'd1);
      checkOutput("drain_data", out_data, DW'(base + k));
      checkOutput("drain_last", 32'(out_last), (k == DEPTH - 1) ? 32'd1 : 32'd0);
      r = toggle ? (c % 2 == 0) : !(inject && c == 0);
      if (inject && c == 0) applyStimulus(1'b1, 32'hDEAD_BEEF, r);
      else                  applyStimulus(1'b0, '0, r);
      @(negedge clk);
      c++;
      if (r) k++;
    end
    checkOutput("drain_cycles", 32'(c), 32'(expCycles));
    checkOutput("frame_done_pulse", 32'(frame_done), 32'd1);
    checkOutput("valid_after_drain", 32'(out_valid), 32'd0);
  endtask

  task automatic idleCycleCheckPulseEnd();
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("frame_done_one_cycle", 32'(frame_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_last", 32'(out_last), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] back-to-back fill, full-rate drain");
    writeSamples(0, DEPTH, 1);
    drainFrame(0, 1'b0, 1'b0);
    idleCycleCheckPulseEnd();
    checkOutput("no_overflow", 32'(overflow), 32'd0);

    $display("[TB] drain with toggling out_ready");
    writeSamples(200, DEPTH, 1);
    drainFrame(200, 1'b1, 1'b0);
    idleCycleCheckPulseEnd();

    $display("[TB] sparse input cadence, overflow injection during drain");
    writeSamples(400, DEPTH, 4);
    drainFrame(400, 1'b0, 1'b1);
    checkOutput("overflow_set", 32'(overflow), 32'd1);
    idleCycleCheckPulseEnd();
    checkOutput("overflow_sticky", 32'(overflow), 32'd1);

    $display("[TB] reset after 100 writes");
    writeSamples(700, 100, 1);
    rst = 1'b1;
    applyStimulus(1'b1, 32'h1234_5678, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("midreset_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_overflow", 32'(overflow), 32'd0);
    checkOutput("midreset_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    writeSamples(1000, DEPTH, 1);
    drainFrame(1000, 1'b0, 1'b0);
    checkOutput("post_reset_overflow", 32'(overflow), 32'd0);

    $display("[TB] next frame starts on the frame_done cycle");
    writeSamples(2000, DEPTH, 1);
    drainFrame(2000, 1'b0, 1'b0);
    idleCycleCheckPulseEnd();
    checkOutput("final_overflow", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pool_flatten_buffer.md
POOL_FLATTEN_BUFFER -- requirements
Module: pool_flatten_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of one pooled sample.
REQ-002 SHALL have parameter WIDTH_IMG, default 26, the pre-pool feature-map side; pooled side OUT_DIM = WIDTH_IMG/2 (13); frame depth DEPTH = OUT_DIM*OUT_DIM (169).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, a pooled-sample strobe driven by the max-pool stage's done.
REQ-006 SHALL have port in_data, input, DATA_WIDTH, the pooled sample, qualified by in_valid.
REQ-007 SHALL have port out_valid, output, 1, asserted when out_data holds a buffered sample.
REQ-008 SHALL have port out_ready, input, 1, the downstream (dense layer) accept signal.
REQ-009 SHALL have port out_data, output, DATA_WIDTH, the flattened sample in raster order.
REQ-010 SHALL have port out_last, output, 1, high with out_valid on sample index DEPTH-1.
REQ-011 SHALL have port frame_done, output, 1, a one-cycle pulse after the final output handshake of a frame.
REQ-012 SHALL have port overflow, output, 1, a sticky flag set when a sample is dropped.

Function
REQ-013 SHALL hold DEPTH entries of DATA_WIDTH bits and use two states: FILL and DRAIN.
REQ-014 SHALL, in FILL with in_valid=1, write in_data to entry wr_idx and increment wr_idx (range 0..DEPTH-1).
REQ-015 SHALL, on a FILL write with wr_idx=DEPTH-1, reset wr_idx to 0 and move to DRAIN on the next cycle.
REQ-016 SHALL, in FILL, ignore cycles with in_valid=0; a sample cycle is any cycle with in_valid=1, with no gap requirement.
REQ-017 SHALL keep out_valid=0 in FILL.
REQ-018 SHALL, in DRAIN, drive out_valid=1 and out_data=entry[rd_idx], with out_data stable while out_valid=1 and out_ready=0.
REQ-019 SHALL count a handshake when out_valid=1 and out_ready=1 in the same cycle, and on each handshake increment rd_idx.
REQ-020 SHALL hold out_valid, out_data and rd_idx unchanged when out_ready=0.
REQ-021 SHALL drive out_last = (state==DRAIN) && (rd_idx==DEPTH-1).
REQ-022 SHALL, on the handshake with out_last=1, reset rd_idx to 0, return to FILL on the next cycle, and pulse frame_done for exactly that next cycle.
REQ-023 SHALL give first-sample latency as follows: the cycle after the DEPTH-th write, out_valid=1 with out_data = the first sample written.
REQ-024 SHALL give a throughput of one sample per cycle when out_ready stays high, completing a drain in exactly DEPTH cycles.
REQ-025 SHALL, when in_valid=1 in DRAIN, drop the sample, leave the buffer unmodified and set overflow=1; overflow stays set until rst.
REQ-026 SHALL accept an in_valid=1 on the same cycle as the return to FILL (the cycle frame_done=1) as entry 0 of the next frame.
REQ-027 SHALL treat all index arithmetic as unsigned, with width ceil(log2(DEPTH)); wr_idx and rd_idx never exceed DEPTH-1.
REQ-028 SHALL produce out_data bit-identical to the written sample, with no arithmetic on data.

Reset
REQ-029 SHALL, while rst=1 at a rising edge, set state=FILL, wr_idx=0, rd_idx=0, out_valid=0, out_last=0, frame_done=0 and overflow=0.
REQ-030 SHALL leave buffer contents undefined after reset and SHALL not drive out_data before the first DRAIN.
REQ-031 SHALL, on rst mid-FILL or mid-DRAIN, discard the partial frame; the next in_valid after reset release is entry 0.
REQ-032 SHALL let rst take priority over simultaneous in_valid and handshakes in the same cycle.

Verification
REQ-033 SHALL pass this scenario: write 169 samples 0..168 back-to-back with out_ready=1 -> out_valid rises the cycle after the last write; outputs are 0..168 in order on consecutive cycles; out_last is high only with 168; frame_done pulses once the next cycle.
REQ-034 SHALL pass this scenario: as REQ-033 but with out_ready toggling 1,0,1,0 -> each value is held while out_ready=0; the drain takes 337 cycles; there are no duplicates or skips.
REQ-035 SHALL pass this scenario: in_valid every 4th cycle (matching the pool cadence) -> there are exactly 169 writes before DRAIN and idle cycles add no entries.
REQ-036 SHALL pass this scenario: in_valid=1 with data 0xDEAD_BEEF during DRAIN -> overflow=1 and persists; the drained stream is unchanged.
REQ-037 SHALL pass this scenario: rst asserted after 100 writes, then 169 new samples 1000..1168 -> the drain outputs 1000..1168 only, with overflow=0.
REQ-038 SHALL pass this scenario: frame 2's first in_valid coincides with frame_done -> frame 2 entry 0 is captured and frame 2 drains 169 correct samples.
